// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo
//
// Byte FIFO with a two-state drain sequencer feeding the usb_pipeline transmit
// port. Producers push at full clock rate; a write attempted while full is
// dropped and latched in a sticky overflow flag rather than back-pressured.
// The sequencer pops one byte at a time, presents it with a one-cycle
// usb_tx_enable_o strobe and then waits, without timeout, for usb_tx_done_i.
//
// Ports
//   clk_i            single clock, rising edge
//   rst_i            asynchronous, active-high reset
//   wr_data_i        byte to enqueue
//   wr_en_i          enqueue wr_data_i this cycle
//   full_o           count == DEPTH
//   empty_o          count == 0
//   level_o          current count, 0..DEPTH
//   overflow_o       sticky, set when a write is dropped
//   usb_tx_data_o    last popped byte, held until the next pop
//   usb_tx_enable_o  one-cycle strobe, usb_tx_data_o valid with it
//   usb_tx_done_i    pipeline accepted the byte (sampled only while waiting)

module usb_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    wr_data_i,
  input  logic          wr_en_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic [7:0]    usb_tx_data_o,
  output logic          usb_tx_enable_o,
  input  logic          usb_tx_done_i
);

  localparam logic [AW:0] DepthCount = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  // Storage array is intentionally not reset.
  logic [7:0]    mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  state_e        state_q;
  logic [7:0]    tx_data_q;
  logic          tx_en_q;

  logic          full;
  logic          empty;
  logic          wr_accept;
  logic          wr_reject;
  logic          pop;

  // Flags come straight off the registered count, so they reflect only what
  // was committed on the previous edge.
  assign full  = (count_q == DepthCount);
  assign empty = (count_q == '0);

  // A pop in the same cycle never rescues a write attempted while full.
  assign wr_accept = wr_en_i && !full;
  assign wr_reject = wr_en_i && full;
  assign pop       = (state_q == StIdle) && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_reject) begin
      overflow_d = 1'b1;
    end

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Drain sequencer with registered outputs. Strobe is asserted on the pop
  // edge and cleared on the following edge regardless of state, so it is
  // always exactly one cycle wide.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          tx_en_q <= 1'b0;
          if (pop) begin
            tx_data_q <= mem_q[rd_ptr_q];
            tx_en_q   <= 1'b1;
            state_q   <= StWait;
          end
        end
        StWait: begin
          tx_en_q <= 1'b0;
          // Done is honoured even in the strobe cycle itself.
          if (usb_tx_done_i) begin
            state_q <= StIdle;
          end
        end
        default: begin
          tx_en_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign full_o          = full;
  assign empty_o         = empty;
  assign level_o         = count_q;
  assign overflow_o      = overflow_q;
  assign usb_tx_data_o   = tx_data_q;
  assign usb_tx_enable_o = tx_en_q;

endmodule

// File: tb/tb_usb_tx_fifo.sv
// Directed bench for usb_tx_fifo: reset, single byte, message order, overflow,
// pointer wrap with stray done pulses, and reset in the middle of a transfer.
module tb_usb_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Responder: 0 = done held low, 1 = done after resp_delay cycles,
  // 2 = done held high (also hits the idle state).
  int resp_mode = 0;
  int resp_delay = 3;
  int resp_cnt = -1;

  int  cyc_cnt = 0;
  logic [7:0] strb_q[$];
  int  strb_t[$];
  logic prev_en = 1'b0;
  logic dbl = 1'b0;

  usb_tx_fifo #(
    .DEPTH(16),
    .AW   (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_data_i      (wr_data),
    .wr_en_i        (wr_en),
    .full_o         (full),
    .empty_o        (empty),
    .level_o        (level),
    .overflow_o     (overflow),
    .usb_tx_data_o  (tx_data),
    .usb_tx_enable_o(tx_en),
    .usb_tx_done_i  (tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      strb_q.push_back(tx_data);
      strb_t.push_back(cyc_cnt);
      if (prev_en) dbl = 1'b1;
    end
    prev_en = (tx_en === 1'b1);
  end

  always @(negedge clk) begin
    if (resp_mode == 2) begin
      tx_done = 1'b1;
      resp_cnt = -1;
    end else if (resp_mode == 1) begin
      if (tx_en === 1'b1) resp_cnt = resp_delay - 1;
      else if (resp_cnt > 0) resp_cnt = resp_cnt - 1;
      else resp_cnt = -1;
      tx_done = (resp_cnt == 0);
    end else begin
      tx_done = 1'b0;
      resp_cnt = -1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic wait_strobes(input string tag, input int n, input int budget);
    int k = 0;
    while (strb_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, strb_q.size(), n);
  endtask

  task automatic clear_log();
    strb_q.delete();
    strb_t.delete();
  endtask

  initial begin
    // Reset asserted between edges, before any clock edge has occurred.
    #2 rst = 1'b1;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_enable", tx_en, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_overflow", overflow, 0);
    step(2);
    rst = 1'b0;
    step(20);
    chk("idle_no_strobe", strb_q.size(), 0);

    // Single byte, responder delay 3.
    resp_mode = 1;
    resp_delay = 3;
    clear_log();
    wr_data = 8'h48;
    wr_en = 1'b1;
    @(negedge clk);  // edge N
    wr_en = 1'b0;
    chk("single_level1", level, 1);
    chk("single_empty0", empty, 0);
    chk("single_en_pre", tx_en, 0);
    @(negedge clk);  // edge N+1
    chk("single_en", tx_en, 1);
    chk("single_data", tx_data, 8'h48);
    chk("single_level0", level, 0);
    @(negedge clk);
    chk("single_en_low", tx_en, 0);
    step(6);
    chk("single_count", strb_q.size(), 1);

    // Message order, back-to-back with responder delay 3.
    clear_log();
    begin
      logic [7:0] msg [7];
      msg = '{8'd72, 8'd101, 8'd108, 8'd108, 8'd111, 8'd33, 8'd10};
      for (int i = 0; i < 7; i++) begin
        wr_data = msg[i];
        wr_en = 1'b1;
        @(negedge clk);
      end
      wr_en = 1'b0;
      wait_strobes("msg_strobes", 7, 60);
      step(6);
      chk("msg_count", strb_q.size(), 7);
      for (int i = 0; i < 7 && i < strb_q.size(); i++) begin
        chk($sformatf("msg_byte%0d", i), strb_q[i], msg[i]);
        if (i > 0) chk($sformatf("msg_gap%0d", i), strb_t[i] - strb_t[i-1], 4);
      end
      chk("msg_empty", empty, 1);
    end

    // Overflow with done held low.
    resp_mode = 0;
    step(2);
    clear_log();
    for (int i = 0; i < 18; i++) begin
      wr_data = 8'(i);
      wr_en = 1'b1;
      @(negedge clk);
      if (i == 16) begin
        chk("ovf_peak_level", level, 16);
        chk("ovf_peak_full", full, 1);
        chk("ovf_not_yet", overflow, 0);
      end
      if (i == 17) begin
        chk("ovf_set", overflow, 1);
        chk("ovf_level_hold", level, 16);
      end
    end
    wr_en = 1'b0;
    chk("ovf_first_popped", strb_q.size(), 1);
    resp_mode = 2;
    wait_strobes("ovf_strobes", 17, 80);
    step(10);
    chk("ovf_count", strb_q.size(), 17);
    for (int i = 0; i < 17 && i < strb_q.size(); i++) begin
      chk($sformatf("ovf_byte%0d", i), strb_q[i], i);
    end
    chk("ovf_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);

    // Wrap-around: fresh reset, 40 bytes at 1 per 3 cycles, done held high.
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    for (int i = 0; i < 40; i++) begin
      wr_data = 8'(8'h80 + i);
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      step(2);
    end
    step(10);
    chk("wrap_count", strb_q.size(), 40);
    for (int i = 0; i < 40 && i < strb_q.size(); i++) begin
      chk($sformatf("wrap_byte%0d", i), strb_q[i], 8'h80 + i);
    end
    chk("wrap_overflow", overflow, 0);
    chk("wrap_empty", empty, 1);

    // Reset in the middle of a transfer with 5 bytes queued.
    resp_mode = 0;
    step(2);
    clear_log();
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h60 + i);
      wr_en = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("mid_level5", level, 5);
    chk("mid_one_strobe", strb_q.size(), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_enable", tx_en, 0);
    chk("mid_level0", level, 0);
    chk("mid_empty", empty, 1);
    chk("mid_data", tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    resp_mode = 1;
    resp_delay = 3;
    step(3);
    chk("mid_no_stale", strb_q.size(), 1);
    clear_log();
    wr_data = 8'hA5;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    chk("post_en", tx_en, 1);
    chk("post_data", tx_data, 8'hA5);
    step(8);
    chk("post_count", strb_q.size(), 1);
    chk("post_level", level, 0);
    chk("one_cycle_strobes", dbl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_tx_fifo.md
# usb_tx_fifo

Byte FIFO and drain sequencer between any byte producer (message formatter, test pattern logic, UART bridge) and the `usb_pipeline` transmit port. Producers push bytes at full clock rate without waiting on USB. The block pops one byte at a time and presents it on the `usb_tx_data`/`usb_tx_enable`/`usb_tx_done` handshake. Overflow is detected and flagged rather than back-pressured.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, minimum 2.
- `AW`, 4, pointer width; must equal log2(`DEPTH`).
- `CLK` in 1: single clock (16 MHz); all logic on its rising edge.
- `RST` in 1: one clock; reset is asynchronous and active-high.
- `wr_data` in 8: byte to enqueue.
- `wr_en` in 1: enqueue `wr_data` this cycle.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `level` out AW+1: current `count` (0..`DEPTH`).
- `overflow` out 1: sticky; set when a write is dropped.
- `usb_tx_data` out 8: byte presented to `usb_pipeline`.
- `usb_tx_enable` out 1: one-cycle strobe; `usb_tx_data` is valid at the strobe.
- `usb_tx_done` in 1: pipeline has accepted the byte.

## Operation
- Storage: `DEPTH`x8 register array, `wr_ptr`/`rd_ptr` of AW bits, plus a registered `count` of AW+1 bits.
- Pointers wrap modulo `DEPTH` with natural AW-bit rollover.
- The array is not reset. All other state is reset.
- Write accept: `wr_en && !full`, evaluated on pre-edge `full`.
  - On accept: `mem[wr_ptr] <= wr_data`, `wr_ptr++`.
  - Rejected write (`wr_en && full`): data discarded, pointers unchanged, `overflow <= 1`.
  - A pop in the same cycle does not rescue a write attempted while full.
- `count` update:
  - +1 on accept only.
  - -1 on pop only.
  - Unchanged on simultaneous accept and pop.
- Drain FSM, 2 states:
  - `S_IDLE`: `usb_tx_enable <= 0`. If `!empty`: pop (`usb_tx_data <= mem[rd_ptr]`, `rd_ptr++`), `usb_tx_enable <= 1`, go to `S_WAIT`. Otherwise stay.
  - `S_WAIT`: `usb_tx_enable <= 0`. If `usb_tx_done`, go to `S_IDLE`; otherwise stay.
- `usb_tx_done` is sampled only in `S_WAIT`, including the cycle where `usb_tx_enable` is high. It is ignored in `S_IDLE`.
- `usb_tx_data` holds the last popped byte until the next pop.
- No timeout: the FSM waits in `S_WAIT` indefinitely for `usb_tx_done`.
- Reset values:
  - `usb_tx_data = 8'h00`, `usb_tx_enable = 0`, `overflow = 0`.
  - `full = 0`, `empty = 1`, `level = 0`, state `S_IDLE`.
  - `wr_ptr = rd_ptr = 0`.
- Reset mid-operation (any state): FIFO contents and any in-flight byte are abandoned. Outputs take reset values asynchronously.

## Timing
- `full`, `empty`, `level`: registered; they reflect writes and pops committed on the previous edge.
- Write-to-strobe latency with FIFO empty and FSM in `S_IDLE`:
  - Write accepted at edge N.
  - `empty` falls after N.
  - Pop and `usb_tx_enable` rise at edge N+1; `usb_tx_enable` is high for exactly one cycle.
- Back-to-back bytes:
  - `usb_tx_done` seen at edge M returns the FSM to `S_IDLE`.
  - Next strobe at edge M+1 if the FIFO is non-empty.
  - Minimum strobe spacing is 2 cycles, when `usb_tx_done` coincides with the strobe cycle.
- Sustained throughput is bounded by the `usb_pipeline` done rate. The write side may accept 1 byte/cycle until full.

## Test plan
- Reset:
  - Assert `RST` asynchronously between edges.
  - Required outputs: `empty=1`, `full=0`, `level=0`, `usb_tx_enable=0`, `usb_tx_data=00`, `overflow=0`.
  - Required state: no strobe for 20 cycles with no writes.
- Single byte:
  - Write `8'h48` at edge N with the responder returning `usb_tx_done` 3 cycles after the strobe.
  - Required: `usb_tx_enable` high only in the cycle after N+1, `usb_tx_data=48`, `level` 1 then 0.
- Message order:
  - Burst-write 72,101,108,108,111,33,10 on consecutive cycles, responder delay 3 cycles.
  - Required: 7 strobes in that exact order, spaced 4 cycles apart, `empty=1` after the last.
- Overflow:
  - Hold `usb_tx_done=0` and write 18 bytes 0x00..0x11.
  - Required: `level` peaks at 16 with `full=1`, `overflow=1` after the 18th write.
  - After releasing `usb_tx_done`, exactly 17 bytes are transmitted: the first byte was popped immediately, so 0x11 is the only byte dropped.
- Wrap-around and simultaneity:
  - Write 40 incrementing bytes at 1 per 3 cycles, with `usb_tx_done` asserted in the strobe cycle.
  - Required: all 40 bytes delivered in order, `overflow=0`.
  - Required: `usb_tx_done` pulses injected while in `S_IDLE` cause no extra strobes.
- Reset mid-transfer:
  - Assert `RST` while in `S_WAIT` with 5 bytes queued.
  - Required: immediate `usb_tx_enable=0`, `level=0`, then normal operation on fresh writes after release.
